dmd_row_capture: RTL

DMD_ROW_CAPTURE -- requirements
Module: dmd_row_capture

---
 rtl/dmd_row_capture.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmd_row_capture.sv
// Captures serial pinball DMD rows (dotclk/sdata/rclk/rdata) into a parallel row
// register with row address, and presents each complete row for a fixed enable window.
module dmd_row_capture #(
  parameter int DOTS        = 128,
  parameter int ROWS        = 32,
  parameter int ENABLE_HOLD = 1952
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dmd_dotclk,
  input  logic            dmd_sdata,
  input  logic            dmd_rclk,
  input  logic            dmd_rdata,
  input  logic            err_clr,
  output logic [DOTS-1:0] rowdata,
  output logic [4:0]      address,
  output logic            enable,
  output logic            frame_start,
  output logic            row_err
);

  localparam int HOLD_W = $clog2(ENABLE_HOLD + 1);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [4:0] next_row(input logic [4:0] idx, input logic first);
    if (first || idx == 5'(ROWS - 1)) return 5'd0;
    return idx + 5'd1;
  endfunction

  state_t            state, state_nxt;
  logic              dotclk_p0, dotclk_p1, dotclk_p2;
  logic              sdata_p0, sdata_p1, sdata_p2;
  logic              rclk_p0, rclk_p1, rclk_p2;
  logic              rdata_p0, rdata_p1, rdata_p2;
  logic [DOTS-1:0]   shift, shift_now;
  logic [7:0]        dot_cnt, dot_cnt_now;
  logic [4:0]        row_idx, row_idx_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              dot_edge, row_edge, row_full;
  logic              vld_p0, vld_p1, bad_row;

  // Stage p0..p2: two-flop synchronizers plus a third flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {dotclk_p0, dotclk_p1, dotclk_p2} <= '0;
      {sdata_p0, sdata_p1, sdata_p2}    <= '0;
      {rclk_p0, rclk_p1, rclk_p2}       <= '0;
      {rdata_p0, rdata_p1, rdata_p2}    <= '0;
    end else begin
      {dotclk_p0, dotclk_p1, dotclk_p2} <= {dmd_dotclk, dotclk_p0, dotclk_p1};
      {sdata_p0, sdata_p1, sdata_p2}    <= {dmd_sdata, sdata_p0, sdata_p1};
      {rclk_p0, rclk_p1, rclk_p2}       <= {dmd_rclk, rclk_p0, rclk_p1};
      {rdata_p0, rdata_p1, rdata_p2}    <= {dmd_rdata, rdata_p0, rdata_p1};
    end
  end

  assign dot_edge = dotclk_p1 & ~dotclk_p2;
  assign row_edge = rclk_p1 & ~rclk_p2;

  // A dot arriving in the same clk as the row latch still belongs to that row
  assign shift_now   = dot_edge ? {sdata_p2, shift[DOTS-1:1]} : shift;
  assign dot_cnt_now = dot_edge ? sat_inc(dot_cnt) : dot_cnt;
  assign row_full    = (dot_cnt_now == 8'(DOTS));

  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    vld_p0      = 1'b0;
    bad_row     = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (row_edge && rdata_p2) begin
          state_nxt   = RUN;
          row_idx_nxt = 5'd0;
          vld_p0      = row_full;
        end
      end
      RUN: begin
        if (row_edge) begin
          row_idx_nxt = next_row(row_idx, rdata_p2);
          vld_p0      = row_full;
          bad_row     = ~row_full;
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  // Stage p1: row assembly, row latch and presentation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_SYNC;
      shift       <= '0;
      dot_cnt     <= '0;
      row_idx     <= '0;
      rowdata     <= '0;
      address     <= '0;
      frame_start <= 1'b0;
      vld_p1      <= 1'b0;
      enable      <= 1'b0;
      hold_cnt    <= '0;
      row_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift       <= shift_now;
      dot_cnt     <= row_edge ? 8'd0 : dot_cnt_now;
      row_idx     <= row_idx_nxt;
      vld_p1      <= vld_p0;
      frame_start <= vld_p0 && (row_idx_nxt == 5'd0);
      if (vld_p0) begin
        rowdata <= shift_now;
        address <= row_idx_nxt;
      end
      // Enable drops while new data loads so downstream sees a fresh rising edge
      if (vld_p0) begin
        enable <= 1'b0;
      end else if (vld_p1) begin
        enable   <= 1'b1;
        hold_cnt <= HOLD_W'(ENABLE_HOLD - 1);
      end else if (enable) begin
        if (hold_cnt == '0) enable <= 1'b0;
        else                hold_cnt <= hold_cnt - 1'b1;
      end
      if (bad_row)      row_err <= 1'b1;
      else if (err_clr) row_err <= 1'b0;
    end
  end

endmodule
